// File: rtl/lieat_ifu_bpu_updq.sv
// Branch-resolution update queue between EXU and the BPU.
// Defers training while the IFU looks up the same index, bounded by a starvation limit.
module lieat_ifu_bpu_updq #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rslv_valid,
  output logic                     rslv_ready,
  input  logic [4:0]               rslv_index,
  input  logic                     rslv_taken,
  input  logic                     lkup_valid,
  input  logic [4:0]               lkup_index,
  input  logic                     hold,
  output logic                     prdt_en,
  output logic [4:0]               prdt_index,
  output logic                     prdt_result,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [15:0]              upd_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX    = SW'(STARVE_MAX);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DEFER = 2'd2;
  localparam logic [1:0] ST_HELD  = 2'd3;

  logic [5:0]    mem_q [DEPTH];
  logic [5:0]    mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [15:0]   upd_q, upd_d;

  logic [5:0] head;
  logic       non_empty;
  logic       conflict;
  logic [1:0] state;
  logic       pop;
  logic       accept;

  assign head      = mem_q[rptr_q];
  assign non_empty = (cnt_q != '0);
  assign conflict  = lkup_valid && (lkup_index == head[5:1]);

  always_comb begin
    state = ST_EMPTY;
    priority case (1'b1)
      !non_empty:                       state = ST_EMPTY;
      hold:                             state = ST_HELD;
      (conflict && starve_q != SMAX):   state = ST_DEFER;
      default:                          state = ST_ISSUE;
    endcase
  end

  // Nothing issues or enters while reset is asserted.
  assign pop        = reset && (state == ST_ISSUE);
  assign rslv_ready = !reset || (cnt_q < DEPTH_C) || pop;
  assign accept     = reset && rslv_valid && rslv_ready;

  assign prdt_en     = pop;
  assign prdt_index  = (reset && non_empty) ? head[5:1] : 5'd0;
  assign prdt_result = reset && non_empty && head[0];
  assign q_count     = cnt_q;
  assign upd_cnt     = upd_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    upd_d  = upd_q;
    if (accept) begin
      mem_d[wptr_q] = {rslv_index, rslv_taken};
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
      if (upd_q != 16'hFFFF) upd_d = upd_q + 16'd1;
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Deferral only happens below the limit, so +1 cannot overshoot.
    starve_d = (state == ST_DEFER) ? starve_q + SW'(1) : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      upd_q    <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      upd_q    <= upd_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_lieat_ifu_bpu_updq.sv
// Bench for lieat_ifu_bpu_updq: cycle vector table
// followed by a scoreboarded stream with random lookup traffic.
module tb_lieat_ifu_bpu_updq;

  logic       clock = 1'b0;
  logic       reset;
  logic       rslv_valid;
  logic       rslv_ready;
  logic [4:0] rslv_index;
  logic       rslv_taken;
  logic       lkup_valid;
  logic [4:0] lkup_index;
  logic       hold;
  logic       prdt_en;
  logic [4:0] prdt_index;
  logic       prdt_result;
  logic [2:0] q_count;
  logic [15:0] upd_cnt;

  always #5 clock = ~clock;

  lieat_ifu_bpu_updq #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .rslv_valid  (rslv_valid),
    .rslv_ready  (rslv_ready),
    .rslv_index  (rslv_index),
    .rslv_taken  (rslv_taken),
    .lkup_valid  (lkup_valid),
    .lkup_index  (lkup_index),
    .hold        (hold),
    .prdt_en     (prdt_en),
    .prdt_index  (prdt_index),
    .prdt_result (prdt_result),
    .q_count     (q_count),
    .upd_cnt     (upd_cnt)
  );

  typedef struct {
    logic       r;
    logic       rv;
    logic [4:0] ri;
    logic       rt;
    logic       lv;
    logic [4:0] li;
    logic       hd;
    logic       e_rdy;
    logic       e_en;
    logic [4:0] e_idx;
    logic       e_res;
    int         e_cnt;
    int         e_upd;
  } vec_t;

  vec_t tbl[$];
  logic [5:0] sb[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic row(input logic r, input logic rv, input int ri,
                     input logic rt, input logic lv, input int li,
                     input logic hd, input logic rdy, input logic en,
                     input int idx, input logic res, input int cnt,
                     input int upd);
    vec_t v;
    v.r = r; v.rv = rv; v.ri = 5'(ri); v.rt = rt;
    v.lv = lv; v.li = 5'(li); v.hd = hd;
    v.e_rdy = rdy; v.e_en = en; v.e_idx = 5'(idx); v.e_res = res;
    v.e_cnt = cnt; v.e_upd = upd;
    tbl.push_back(v);
  endtask

  initial begin
    logic [5:0] exp_e;
    int sent;
    int got;
    string tag;

    // r  rv ri rt lv li hd | rdy en idx res cnt upd
    row(0, 1, 3, 1, 1, 3, 1,   1, 0, 0, 0, 0, 0);
    row(1, 1, 5, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 0, 0, 0,   1, 1, 5, 1, 1, 0);
    row(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
    row(1, 1, 7, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
    row(1, 0, 0, 0, 1, 7, 0,   1, 0, 7, 0, 1, 1);
    row(1, 0, 0, 0, 1, 7, 0,   1, 0, 7, 0, 1, 1);
    row(1, 0, 0, 0, 1, 7, 0,   1, 0, 7, 0, 1, 1);
    row(1, 0, 0, 0, 1, 7, 0,   1, 1, 7, 0, 1, 1);
    row(1, 1, 7, 1, 0, 0, 0,   1, 0, 0, 0, 0, 2);
    row(1, 0, 0, 0, 1, 8, 0,   1, 1, 7, 1, 1, 2);
    row(1, 1, 1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 3);
    row(1, 1, 2, 0, 0, 0, 1,   1, 0, 1, 1, 1, 3);
    row(1, 1, 3, 1, 0, 0, 1,   1, 0, 1, 1, 2, 3);
    row(1, 1, 4, 0, 0, 0, 1,   1, 0, 1, 1, 3, 3);
    row(1, 1, 9, 1, 0, 0, 1,   0, 0, 1, 1, 4, 3);
    row(1, 1, 10, 1, 0, 0, 0,  1, 1, 1, 1, 4, 3);
    row(1, 0, 0, 0, 0, 0, 0,   1, 1, 2, 0, 4, 4);
    row(1, 0, 0, 0, 0, 0, 0,   1, 1, 3, 1, 3, 5);
    row(1, 0, 0, 0, 0, 0, 0,   1, 1, 4, 0, 2, 6);
    row(1, 0, 0, 0, 0, 0, 0,   1, 1, 10, 1, 1, 7);
    row(1, 1, 11, 0, 0, 0, 0,  1, 0, 0, 0, 0, 8);
    row(1, 1, 12, 1, 0, 0, 1,  1, 0, 11, 0, 1, 8);
    row(1, 1, 13, 0, 0, 0, 1,  1, 0, 11, 0, 2, 8);
    row(0, 1, 14, 0, 1, 11, 0, 1, 0, 0, 0, 3, 8);
    row(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    row(1, 1, 20, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 1, 20, 0,  1, 0, 20, 1, 1, 0);
    row(1, 0, 0, 0, 1, 20, 0,  1, 0, 20, 1, 1, 0);
    row(1, 0, 0, 0, 1, 20, 1,  1, 0, 20, 1, 1, 0);
    row(1, 0, 0, 0, 1, 20, 0,  1, 0, 20, 1, 1, 0);
    row(1, 0, 0, 0, 1, 20, 0,  1, 0, 20, 1, 1, 0);
    row(1, 0, 0, 0, 1, 20, 0,  1, 0, 20, 1, 1, 0);
    row(1, 0, 0, 0, 1, 20, 0,  1, 1, 20, 1, 1, 0);
    row(1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1);

    reset = 1'b0; rslv_valid = 1'b0; rslv_index = '0; rslv_taken = 1'b0;
    lkup_valid = 1'b0; lkup_index = '0; hold = 1'b0;
    @(posedge clock);

    foreach (tbl[i]) begin
      @(negedge clock);
      reset = tbl[i].r; rslv_valid = tbl[i].rv;
      rslv_index = tbl[i].ri; rslv_taken = tbl[i].rt;
      lkup_valid = tbl[i].lv; lkup_index = tbl[i].li;
      hold = tbl[i].hd;
      #1;
      tag = $sformatf("row%0d", i);
      chk({tag, "_ready"}, int'(rslv_ready), int'(tbl[i].e_rdy));
      chk({tag, "_en"}, int'(prdt_en), int'(tbl[i].e_en));
      chk({tag, "_idx"}, int'(prdt_index), int'(tbl[i].e_idx));
      chk({tag, "_res"}, int'(prdt_result), int'(tbl[i].e_res));
      chk({tag, "_cnt"}, int'(q_count), tbl[i].e_cnt);
      chk({tag, "_upd"}, int'(upd_cnt), tbl[i].e_upd);
    end

    // Indices 0..9 streamed through with random lookup interference.
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 300 && (sent < 10 || got < 10); cyc++) begin
      @(negedge clock);
      reset = 1'b1; hold = 1'b0;
      rslv_valid = (sent < 10);
      rslv_index = 5'(sent);
      rslv_taken = sent[0];
      lkup_valid = 1'($urandom_range(0, 1));
      lkup_index = 5'($urandom_range(0, 9));
      #1;
      if (prdt_en) begin
        if (sb.size() == 0) begin
          chk("sb_spurious", 1, 0);
        end else begin
          exp_e = sb.pop_front();
          chk($sformatf("sb_idx%0d", got), int'(prdt_index), int'(exp_e[5:1]));
          chk($sformatf("sb_res%0d", got), int'(prdt_result), int'(exp_e[0]));
          got++;
        end
      end
      if (rslv_valid && rslv_ready) begin
        sb.push_back({rslv_index, rslv_taken});
        sent++;
      end
    end
    chk("sb_sent", sent, 10);
    chk("sb_got", got, 10);

    @(negedge clock);
    rslv_valid = 1'b0; lkup_valid = 1'b0;
    #1;
    chk("sb_final_cnt", int'(q_count), 0);
    chk("sb_final_upd", int'(upd_cnt), 11);
    chk("sb_final_en", int'(prdt_en), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
